// File: rtl/itch_stream_decoder.sv
// Streaming ITCH decoder: assembles beats into a byte buffer, then decodes Add Order,
// Order Cancel and Order Delete, or reports why the message was rejected.
// state   | meaning
// COLLECT | accepting beats into the buffer
// EMIT    | result pending: a decoded message (held until out_ready) or a one-cycle error
module itch_stream_decoder #(
  parameter int BEAT_BYTES    = 1,
  parameter int MAX_MSG_BYTES = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [8*BEAT_BYTES-1:0]            in_data,
  input  logic                               in_last,
  input  logic [$clog2(BEAT_BYTES+1)-1:0]    in_cnt,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [1:0]                         out_type,
  output logic [63:0]                        order_ref,
  output logic                               buy_sell,
  output logic [31:0]                        shares,
  output logic [63:0]                        stock_symbol,
  output logic [31:0]                        price,
  output logic                               err_valid,
  output logic [1:0]                         err_code,
  output logic [31:0]                        msg_count
);

  localparam int CNT_W = $clog2(MAX_MSG_BYTES + 2);
  localparam int IDX_W = $clog2(MAX_MSG_BYTES);

  typedef enum logic {COLLECT, EMIT} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         buf_q [MAX_MSG_BYTES];
  logic [7:0]         buf_d [MAX_MSG_BYTES];
  logic [31:0]        msg_count_q, msg_count_d;

  logic               known;
  logic [1:0]         kind;
  logic [1:0]         code;
  logic [CNT_W-1:0]   exp_len;

  // Classification of the buffered message; priority overflow > empty/unknown type > length.
  always_comb begin
    known   = 1'b1;
    kind    = 2'd0;
    exp_len = CNT_W'(26);
    case (buf_q[0])
      8'h41: begin kind = 2'd0; exp_len = CNT_W'(26); end
      8'h58: begin kind = 2'd1; exp_len = CNT_W'(13); end
      8'h44: begin kind = 2'd2; exp_len = CNT_W'(9);  end
      default: known = 1'b0;
    endcase
    if (ovf_q)                    code = 2'd3;
    else if (byte_cnt_q == '0)    code = 2'd2;
    else if (!known)              code = 2'd1;
    else if (byte_cnt_q != exp_len) code = 2'd2;
    else                          code = 2'd0;
  end

  always_comb begin
    int nb;
    int off;
    int sum;
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    ovf_d       = ovf_q;
    buf_d       = buf_q;
    msg_count_d = msg_count_q;
    nb          = BEAT_BYTES;
    off         = 0;
    sum         = 0;
    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          if (in_last && int'(in_cnt) < BEAT_BYTES) nb = int'(in_cnt);
          for (int i = 0; i < BEAT_BYTES; i++) begin
            if (i < nb) begin
              off = int'(byte_cnt_q) + i;
              if (off < MAX_MSG_BYTES) buf_d[IDX_W'(off)] = in_data[8*(BEAT_BYTES-1-i) +: 8];
              else                     ovf_d = 1'b1;
            end
          end
          sum = int'(byte_cnt_q) + nb;
          if (sum > MAX_MSG_BYTES + 1) sum = MAX_MSG_BYTES + 1;
          byte_cnt_d = CNT_W'(sum);
          if (in_last) state_d = EMIT;
        end
      end
      EMIT: begin
        if (code != 2'd0 || out_ready) begin
          state_d    = COLLECT;
          byte_cnt_d = '0;
          ovf_d      = 1'b0;
          if (code == 2'd0) msg_count_d = msg_count_q + 32'd1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      byte_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      msg_count_q <= '0;
      for (int i = 0; i < MAX_MSG_BYTES; i++) buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      ovf_q       <= ovf_d;
      msg_count_q <= msg_count_d;
      buf_q       <= buf_d;
    end
  end

  // Fields come straight from the buffer, which cannot change while EMIT holds.
  always_comb begin
    out_valid    = 1'b0;
    err_valid    = 1'b0;
    err_code     = 2'd0;
    out_type     = 2'd0;
    order_ref    = '0;
    buy_sell     = 1'b0;
    shares       = '0;
    stock_symbol = '0;
    price        = '0;
    if (state_q == EMIT) begin
      if (code == 2'd0) begin
        out_valid = 1'b1;
        out_type  = kind;
        order_ref = {buf_q[1], buf_q[2], buf_q[3], buf_q[4],
                     buf_q[5], buf_q[6], buf_q[7], buf_q[8]};
        if (kind == 2'd0) begin
          buy_sell     = (buf_q[9] == 8'h42);
          shares       = {buf_q[10], buf_q[11], buf_q[12], buf_q[13]};
          stock_symbol = {buf_q[14], buf_q[15], buf_q[16], buf_q[17],
                          buf_q[18], buf_q[19], buf_q[20], buf_q[21]};
          price        = {buf_q[22], buf_q[23], buf_q[24], buf_q[25]};
        end else if (kind == 2'd1) begin
          shares = {buf_q[9], buf_q[10], buf_q[11], buf_q[12]};
        end
      end else begin
        err_valid = 1'b1;
        err_code  = code;
      end
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign msg_count = msg_count_q;

endmodule

// File: tb/tb_itch_stream_decoder.sv
// Bench for itch_stream_decoder: three instances (1, 4 and 8 byte beats) driven one at a
// time, checked against a byte-queue reference model, directed vectors and corner sequences.
module tb_itch_stream_decoder;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    bit          ok;
    logic [1:0]  code;
    logic [1:0]  typ;
    logic [63:0] rf;
    logic        bs;
    logic [31:0] sh;
    logic [63:0] stk;
    logic [31:0] pr;
  } exp_t;
  typedef struct {
    int         sel;
    logic [7:0] t;
    int         len;
    bit         ok;
    logic [1:0] code;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_last;
  logic [3:0]  in_cnt;
  logic        out_ready;
  int          sel;

  logic        ir [3];
  logic        ov [3];
  logic        bs [3];
  logic        ev [3];
  logic [1:0]  ot [3];
  logic [1:0]  ec [3];
  logic [63:0] orf [3];
  logic [63:0] stk [3];
  logic [31:0] sh [3];
  logic [31:0] pr [3];
  logic [31:0] mc [3];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_cnt [3];
  int bbs [3] = '{1, 4, 8};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  itch_stream_decoder #(.BEAT_BYTES(1), .MAX_MSG_BYTES(32)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(ir[0]),
    .in_data(in_data[63:56]), .in_last(in_last), .in_cnt(in_cnt[0:0]),
    .out_valid(ov[0]), .out_ready(out_ready), .out_type(ot[0]), .order_ref(orf[0]),
    .buy_sell(bs[0]), .shares(sh[0]), .stock_symbol(stk[0]), .price(pr[0]),
    .err_valid(ev[0]), .err_code(ec[0]), .msg_count(mc[0]));

  itch_stream_decoder #(.BEAT_BYTES(4), .MAX_MSG_BYTES(32)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(ir[1]),
    .in_data(in_data[63:32]), .in_last(in_last), .in_cnt(in_cnt[2:0]),
    .out_valid(ov[1]), .out_ready(out_ready), .out_type(ot[1]), .order_ref(orf[1]),
    .buy_sell(bs[1]), .shares(sh[1]), .stock_symbol(stk[1]), .price(pr[1]),
    .err_valid(ev[1]), .err_code(ec[1]), .msg_count(mc[1]));

  itch_stream_decoder #(.BEAT_BYTES(8), .MAX_MSG_BYTES(32)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2), .in_ready(ir[2]),
    .in_data(in_data), .in_last(in_last), .in_cnt(in_cnt),
    .out_valid(ov[2]), .out_ready(out_ready), .out_type(ot[2]), .order_ref(orf[2]),
    .buy_sell(bs[2]), .shares(sh[2]), .stock_symbol(stk[2]), .price(pr[2]),
    .err_valid(ev[2]), .err_code(ec[2]), .msg_count(mc[2]));

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", nm, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] be(bq_t q, int off, int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = (v << 8) | 64'(q[off + i]);
    return v;
  endfunction

  function automatic bq_t app(bq_t q, logic [63:0] v, int n);
    bq_t r = q;
    for (int i = n - 1; i >= 0; i--) r.push_back(v[8*i +: 8]);
    return r;
  endfunction

  // Reference: message meaning from its byte list and length alone.
  function automatic exp_t model(bq_t q);
    exp_t m;
    int   len = q.size();
    int   need = 0;
    m = '{default: '0};
    if (len > 32) m.code = 2'd3;
    else if (len == 0) m.code = 2'd2;
    else begin
      if (q[0] == "A")      begin m.typ = 2'd0; need = 26; end
      else if (q[0] == "X") begin m.typ = 2'd1; need = 13; end
      else if (q[0] == "D") begin m.typ = 2'd2; need = 9;  end
      else m.code = 2'd1;
      if (m.code == 2'd0 && len != need) m.code = 2'd2;
    end
    if (m.code == 2'd0) begin
      m.ok = 1'b1;
      m.rf = be(q, 1, 8);
      if (m.typ == 2'd0) begin
        m.bs  = (q[9] == 8'h42);
        m.sh  = 32'(be(q, 10, 4));
        m.stk = be(q, 14, 8);
        m.pr  = 32'(be(q, 22, 4));
      end else if (m.typ == 2'd1) begin
        m.sh = 32'(be(q, 9, 4));
      end
    end else begin
      m.typ = 2'd0;
    end
    return m;
  endfunction

  // Drives the whole message; returns one cycle after the last beat was taken.
  task automatic send_msg(input bq_t q, input bit gaps);
    int bb = bbs[sel];
    int n = q.size();
    int pos = 0;
    bit last = 1'b0;
    do begin
      int cnt;
      int guard = 0;
      bit r;
      logic [63:0] d;
      cnt  = (n - pos > bb) ? bb : n - pos;
      last = (n - pos <= bb);
      d    = {$urandom, $urandom};
      for (int i = 0; i < cnt; i++) d[63 - 8*i -: 8] = q[pos + i];
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        step();
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      in_cnt   = 4'(cnt);
      do begin
        r = ir[sel];
        step();
        guard++;
      end while (!r && guard < 100);
      if (!r) chk("in_ready_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = {$urandom, $urandom};
      pos += cnt;
    end while (!last);
  endtask

  task automatic check_result(input exp_t m);
    if (m.ok) begin
      chk("out_valid", 64'(ov[sel]), 64'd1);
      chk("err_valid_on_ok", 64'(ev[sel]), 64'd0);
      chk("out_type", 64'(ot[sel]), 64'(m.typ));
      chk("order_ref", orf[sel], m.rf);
      chk("buy_sell", 64'(bs[sel]), 64'(m.bs));
      chk("shares", 64'(sh[sel]), 64'(m.sh));
      chk("stock_symbol", stk[sel], m.stk);
      chk("price", 64'(pr[sel]), 64'(m.pr));
      chk("msg_count", 64'(mc[sel]), 64'(32'(exp_cnt[sel])));
      if (out_ready) exp_cnt[sel]++;
    end else begin
      chk("err_valid", 64'(ev[sel]), 64'd1);
      chk("err_code", 64'(ec[sel]), 64'(m.code));
      chk("out_valid_on_err", 64'(ov[sel]), 64'd0);
      chk("msg_count_on_err", 64'(mc[sel]), 64'(32'(exp_cnt[sel])));
      step();
      chk("err_pulse_len", 64'(ev[sel]), 64'd0);
      chk("in_ready_after_err", 64'(ir[sel]), 64'd1);
    end
  endtask

  initial begin
    vec_t vecs [12];
    bq_t  q;
    exp_t m;
    int   prev;
    int   t;

    vecs[0]  = '{0, "A", 26, 1'b1, 2'd0};
    vecs[1]  = '{1, "X", 13, 1'b1, 2'd0};
    vecs[2]  = '{2, "D", 9,  1'b1, 2'd0};
    vecs[3]  = '{0, "Z", 9,  1'b0, 2'd1};
    vecs[4]  = '{1, "A", 25, 1'b0, 2'd2};
    vecs[5]  = '{2, "A", 40, 1'b0, 2'd3};
    vecs[6]  = '{1, "D", 0,  1'b0, 2'd2};
    vecs[7]  = '{2, "X", 9,  1'b0, 2'd2};
    vecs[8]  = '{0, "D", 32, 1'b0, 2'd2};
    vecs[9]  = '{1, "D", 33, 1'b0, 2'd3};
    vecs[10] = '{2, "Z", 40, 1'b0, 2'd3};
    vecs[11] = '{2, "A", 26, 1'b1, 2'd0};

    in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_cnt = '0;
    out_ready = 1'b1; sel = 0; rst_n = 1'b0;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("rst_in_ready", 64'(ir[s]), 64'd1);
      chk("rst_out_valid", 64'(ov[s]), 64'd0);
      chk("rst_out_type", 64'(ot[s]), 64'd0);
      chk("rst_fields", orf[s] | stk[s] | 64'(sh[s]) | 64'(pr[s]) | 64'(bs[s]), 64'd0);
      chk("rst_err", 64'({ev[s], ec[s]}), 64'd0);
      chk("rst_msg_count", 64'(mc[s]), 64'd0);
    end
    rst_n = 1'b1;
    step();

    // Add Order, single-byte beats
    sel = 0;
    q = {8'h41};
    q = app(q, 64'h0123456789ABCDEF, 8);
    q = app(q, 64'h42, 1);
    q = app(q, 64'd100, 4);
    q = app(q, 64'h4141504C20202020, 8);
    q = app(q, 64'd1500000, 4);
    send_msg(q, 1'b0);
    check_result(model(q));
    chk("A_ref", orf[0], 64'h0123456789ABCDEF);
    chk("A_side", 64'(bs[0]), 64'd1);
    chk("A_shares", 64'(sh[0]), 64'd100);
    chk("A_stock", stk[0], 64'h4141504C20202020);
    chk("A_price", 64'(pr[0]), 64'd1500000);
    step();
    chk("A_msg_count", 64'(mc[0]), 64'd1);

    // Order Cancel, 4-byte beats, partial last beat
    sel = 1;
    q = {8'h58};
    q = app(q, 64'h1122334455667788, 8);
    q = app(q, 64'd50, 4);
    send_msg(q, 1'b0);
    check_result(model(q));
    chk("X_type", 64'(ot[1]), 64'd1);
    chk("X_shares", 64'(sh[1]), 64'd50);
    chk("X_price", 64'(pr[1]), 64'd0);
    chk("X_stock", stk[1], 64'd0);

    // Order Delete held by out_ready low for 5 cycles
    sel = 2;
    q = {8'h44};
    q = app(q, {$urandom, $urandom}, 8);
    m = model(q);
    out_ready = 1'b0;
    send_msg(q, 1'b0);
    check_result(m);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_last = 1'b1; in_cnt = 4'd8; in_data = {$urandom, $urandom};
      step();
      chk("hold_out_valid", 64'(ov[2]), 64'd1);
      chk("hold_in_ready", 64'(ir[2]), 64'd0);
      chk("hold_ref", orf[2], m.rf);
      chk("hold_msg_count", 64'(mc[2]), 64'(32'(exp_cnt[2])));
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    step();
    exp_cnt[2]++;
    chk("release_out_valid", 64'(ov[2]), 64'd0);
    chk("release_in_ready", 64'(ir[2]), 64'd1);
    chk("release_msg_count", 64'(mc[2]), 64'(32'(exp_cnt[2])));
    q = {8'h44};
    q = app(q, {$urandom, $urandom}, 8);
    send_msg(q, 1'b0);
    check_result(model(q));

    // Directed vector table
    foreach (vecs[k]) begin
      sel = vecs[k].sel;
      q = {};
      if (vecs[k].len > 0) q.push_back(vecs[k].t);
      while (q.size() < vecs[k].len) q.push_back(8'($urandom));
      m = model(q);
      m.ok = vecs[k].ok;
      m.code = vecs[k].code;
      send_msg(q, 1'b0);
      check_result(m);
    end

    // Reset after 10 bytes of an Add Order, then a Delete
    sel = 0;
    for (int b = 0; b < 10; b++) begin
      in_valid = 1'b1; in_last = 1'b0;
      in_data = {(b == 0) ? 8'h41 : 8'($urandom), 56'd0};
      step();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(ov[0]), 64'd0);
    chk("midrst_err_valid", 64'(ev[0]), 64'd0);
    chk("midrst_in_ready", 64'(ir[0]), 64'd1);
    chk("midrst_msg_count", 64'(mc[0]), 64'd0);
    chk("midrst_ref", orf[0], 64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    step();
    chk("postrst_err_valid", 64'(ev[0]), 64'd0);
    q = {8'h44};
    q = app(q, 64'hCAFEF00D12345678, 8);
    send_msg(q, 1'b0);
    check_result(model(q));
    step();
    chk("postrst_msg_count", 64'(mc[0]), 64'd1);

    // Reset while a decoded result is pending
    sel = 1;
    out_ready = 1'b0;
    send_msg(q, 1'b0);
    check_result(model(q));
    #2 rst_n = 1'b0;
    #1;
    chk("emitrst_out_valid", 64'(ov[1]), 64'd0);
    chk("emitrst_err_valid", 64'(ev[1]), 64'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    step();

    // Back-to-back Deletes on 8-byte beats
    sel = 2;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      q = {8'h44};
      q = app(q, {$urandom, $urandom}, 8);
      send_msg(q, 1'b0);
      t = cyc;
      check_result(model(q));
      if (k > 0) chk("b2b_period", 64'(t - prev), 64'd3);
      prev = t;
    end
    step();
    chk("b2b_msg_count", 64'(mc[2]), 64'(32'(exp_cnt[2])));

    // Randomized messages against the reference model
    for (int k = 0; k < 60; k++) begin
      int r;
      int len;
      logic [7:0] ty;
      sel = $urandom_range(0, 2);
      r = $urandom_range(0, 7);
      if (r < 3)      begin ty = 8'h41; len = 26; end
      else if (r < 5) begin ty = 8'h58; len = 13; end
      else if (r < 7) begin ty = 8'h44; len = 9;  end
      else            begin ty = 8'($urandom); len = 9; end
      if ($urandom_range(0, 4) == 0) len = $urandom_range(0, 40);
      q = {};
      if (len > 0) q.push_back(ty);
      while (q.size() < len) q.push_back(8'($urandom));
      if (len > 9 && $urandom_range(0, 1) == 1) q[9] = 8'h42;
      send_msg(q, 1'b1);
      check_result(model(q));
    end
    step();
    for (int s = 0; s < 3; s++) chk("final_msg_count", 64'(mc[s]), 64'(32'(exp_cnt[s])));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/itch_stream_decoder.md
# itch_stream_decoder

Streaming successor to the single-shot Add Order decoder. Accepts ITCH payload bytes as a beat stream of parametrised width with valid/ready handshake. Assembles each message into an internal buffer and decodes Add Order ('A'), Order Cancel ('X') and Order Delete ('D'). Decoded fields are presented through a valid/ready output port, and malformed messages are reported through an error pulse. Sits between the payload framer and the order-book dispatcher.

## Interface
- BEAT_BYTES, 1, payload bytes per input beat (1..8)
- MAX_MSG_BYTES, 32, buffer capacity in bytes (must be >= 26)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  decoder can accept a beat
- in_data  in  8*BEAT_BYTES  payload bytes; first byte in time at MSB
- in_last  in  1  beat is the final beat of a message
- in_cnt  in  $clog2(BEAT_BYTES+1)  valid bytes in a last beat (MSB-aligned); ignored on non-last beats, which are always full
- out_valid  out  1  decoded message available
- out_ready  in  1  consumer accepts the message
- out_type  out  2  message kind: 0='A', 1='X', 2='D'
- order_ref  out  64  order reference number
- buy_sell  out  1  side; 1 when the side byte is 'B' (0x42), else 0; 'A' only
- shares  out  32  shares ('A') or cancelled shares ('X')
- stock_symbol  out  64  symbol; 'A' only
- price  out  32  price; 'A' only
- err_valid  out  1  one-cycle pulse for a rejected message
- err_code  out  2  1=unknown type, 2=length mismatch, 3=overflow
- msg_count  out  32  count of successfully decoded messages; wraps

## Operation
- Two states: COLLECT and EMIT. Reset enters COLLECT.
- COLLECT: in_ready=1.
  - Each accepted beat writes its bytes at buffer offset byte_cnt; byte_cnt advances by BEAT_BYTES, or by in_cnt on a last beat.
  - Bytes at offsets >= MAX_MSG_BYTES are dropped and set the overflow flag.
  - byte_cnt saturates at MAX_MSG_BYTES+1.
  - An accepted in_last moves the block to EMIT with final length L.
- EMIT: in_ready=0. The message is classified with priority overflow > unknown type > length.
  - Byte 0 is the type.
  - Valid lengths: 'A' L=26, 'X' L=13, 'D' L=9.
  - L=0 reports code 2.
- Field byte offsets, all big-endian:
  - 'A': ref 1-8, side 9, shares 10-13, stock 14-21, price 22-25.
  - 'X': ref 1-8, shares 9-12.
  - 'D': ref 1-8.
- Fields unused by the decoded type are driven 0.
- Valid message:
  - out_valid=1 and all fields are held stable until out_ready.
  - On the out_valid&&out_ready cycle, msg_count increments and the block returns to COLLECT with byte_cnt=0 and overflow cleared.
- Rejected message:
  - err_valid=1 for exactly one cycle with err_code set.
  - out_valid stays 0 and msg_count is unchanged.
  - The block returns to COLLECT on the next cycle.
- A new message starts on the first beat accepted after the return to COLLECT.

## Timing
- Reset values:
  - state=COLLECT, in_ready=1, out_valid=0, out_type=0.
  - order_ref, buy_sell, shares, stock_symbol, price all 0.
  - err_valid=0, err_code=0, msg_count=0.
  - byte_cnt=0, overflow flag clear.
- Latency: in_last accepted at cycle T gives out_valid=1 (or err_valid=1) at T+1.
- in_ready is registered-state based and is 0 throughout EMIT. No input is accepted while a result is pending.
- out_ready held high: 1 cycle in EMIT, and the next beat is accepted at T+2. Single-byte messages therefore sustain one message per L+1 cycles at BEAT_BYTES=1.
- out_ready low: out_valid and fields hold indefinitely, and in_valid is ignored.
- in_valid with in_ready=0 has no effect. in_data, in_last and in_cnt are sampled only on in_valid&&in_ready.
- Reset mid-message or mid-EMIT discards the partial message and pending output immediately, with no err pulse. Normal operation resumes on the first clock edge after deassertion.
- msg_count wraps from 0xFFFFFFFF to 0.

## Test plan
- BEAT_BYTES=1, 'A' 26 bytes: ref=0x0123456789ABCDEF, side 'B', shares=100, stock "AAPL    ", price=1500000.
  - Required: out_valid at T+1 with out_type=0, buy_sell=1, matching fields, msg_count=1.
- BEAT_BYTES=4, 'X' 13 bytes (4 beats, last in_cnt=1), shares=50.
  - Required: out_type=1, shares=50, price=0, stock_symbol=0.
- 'D' 9 bytes with out_ready low for 5 cycles.
  - Required: fields stable, in_ready=0 throughout; accepted on the first ready cycle; the next message decodes correctly.
- Error cases:
  - 'Z' of 9 bytes gives err_code=1.
  - 'A' of 25 bytes gives err_code=2.
  - 40-byte 'A' gives err_code=3.
  - In every case: one-cycle pulse, no out_valid, msg_count unchanged.
- rst_n asserted after 10 bytes of an 'A', then a full 'D' sent.
  - Required: all outputs return to reset values, no error pulse, and the 'D' decodes with msg_count=1.
- Back-to-back 'D' messages, BEAT_BYTES=8, out_ready=1.
  - Required: out_valid every 3 cycles and msg_count increments by 1 per message.
